fantasy_fade: RTL and testbench

FANTASY_FADE -- requirements
Module: fantasy_fade

---
 rtl/fantasy_fade.sv | 145 ++++++++++++++
 tb/tb_fantasy_fade.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fantasy_fade.sv
// Per-pixel colour inversion blended by a frame-synchronous fade level.
// Fixed 3-cycle latency; no backpressure, one pixel accepted and emitted every cycle.
module fantasy_fade #(
  parameter int CW     = 8,
  parameter int NC     = 3,
  parameter int AW     = 4,
  parameter int STEP   = 1,
  parameter int VS_POL = 1
) (
  input  logic                vin_clk_i,
  input  logic                rst_n,
  input  logic                vin_hs_i,
  input  logic                vin_vs_i,
  input  logic                vin_de_i,
  input  logic [CW*NC-1:0]    vin_data_i,
  input  logic                px_x_i,
  input  logic [2:0]          mode_i,
  input  logic                bypass_i,
  output logic                vout_hs_o,
  output logic                vout_vs_o,
  output logic                vout_de_o,
  output logic [CW*NC-1:0]    vout_data_o,
  output logic [AW:0]         alpha_o,
  output logic                fade_busy_o
);

  localparam int DW = CW * NC;
  localparam int PW = CW + AW + 1;
  localparam int SW = CW + AW + 2;
  localparam logic [AW:0]   A_V    = {1'b1, {AW{1'b0}}};
  localparam logic [CW-1:0] M_V    = {CW{1'b1}};
  localparam logic [AW+1:0] STEP_V = (AW+2)'(STEP);
  localparam logic          VS_ACT = 1'(VS_POL);

  logic              hs_s1, vs_s1, de_s1;
  logic [DW-1:0]     dat_s1;
  logic [AW:0]       a_s1;
  logic              hs_s2, vs_s2, de_s2;
  logic [NC-1:0][PW-1:0] p0_s2, p1_s2;

  logic [AW:0]       alpha, tgt;
  logic [AW:0]       alpha_nxt, tgt_nxt;
  logic [AW+1:0]     up, dn;
  logic              px_inv, frame_start;
  logic [SW-1:0]     sum_v;
  logic [DW-1:0]     out_nxt;

  always_comb begin
    px_inv = 1'b0;
    if (!bypass_i) begin
      case (mode_i)
        3'd0:    px_inv = 1'b0;
        3'd1:    px_inv = 1'b1;
        default: px_inv = mode_i[0] ? ~px_x_i : px_x_i;
      endcase
    end
  end

  // vs_s2 is vs_s1 one cycle later, so this is a single pulse per frame.
  assign frame_start = (vs_s1 == VS_ACT) && (vs_s2 != VS_ACT);
  assign tgt_nxt     = (mode_i == 3'd0) ? '0 : A_V;

  always_comb begin
    up        = {1'b0, alpha} + STEP_V;
    dn        = {1'b0, alpha} - {1'b0, tgt_nxt};
    alpha_nxt = alpha;
    if (alpha < tgt_nxt)
      alpha_nxt = (up >= {1'b0, tgt_nxt}) ? tgt_nxt : up[AW:0];
    else if (alpha > tgt_nxt)
      alpha_nxt = (dn <= STEP_V) ? tgt_nxt : alpha - STEP_V[AW:0];
  end

  always_ff @(posedge vin_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      alpha       <= '0;
      tgt         <= '0;
      fade_busy_o <= 1'b0;
    end else if (frame_start) begin
      alpha       <= alpha_nxt;
      tgt         <= tgt_nxt;
      fade_busy_o <= (alpha_nxt != tgt_nxt);
    end
  end

  assign alpha_o = alpha;

  always_ff @(posedge vin_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      hs_s1  <= 1'b0;
      vs_s1  <= 1'b0;
      de_s1  <= 1'b0;
      dat_s1 <= '0;
      a_s1   <= '0;
    end else begin
      hs_s1  <= vin_hs_i;
      vs_s1  <= vin_vs_i;
      de_s1  <= vin_de_i;
      dat_s1 <= vin_data_i;
      a_s1   <= px_inv ? alpha : '0;
    end
  end

  // d*(A-a) and (M-d)*a, kept full width so the blend never overflows.
  always_ff @(posedge vin_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      hs_s2 <= 1'b0;
      vs_s2 <= 1'b0;
      de_s2 <= 1'b0;
      p0_s2 <= '0;
      p1_s2 <= '0;
    end else begin
      hs_s2 <= hs_s1;
      vs_s2 <= vs_s1;
      de_s2 <= de_s1;
      for (int k = 0; k < NC; k++) begin
        p0_s2[k] <= PW'(dat_s1[k*CW +: CW]) * PW'(A_V - a_s1);
        p1_s2[k] <= PW'(M_V - dat_s1[k*CW +: CW]) * PW'(a_s1);
      end
    end
  end

  always_comb begin
    out_nxt = '0;
    sum_v   = '0;
    for (int k = 0; k < NC; k++) begin
      sum_v = SW'(p0_s2[k]) + SW'(p1_s2[k]) + SW'(A_V >> 1);
      out_nxt[k*CW +: CW] = sum_v[AW +: CW];
    end
  end

  always_ff @(posedge vin_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vout_hs_o   <= 1'b0;
      vout_vs_o   <= 1'b0;
      vout_de_o   <= 1'b0;
      vout_data_o <= '0;
    end else begin
      vout_hs_o   <= hs_s2;
      vout_vs_o   <= vs_s2;
      vout_de_o   <= de_s2;
      vout_data_o <= out_nxt;
    end
  end

endmodule

// File: tb/tb_fantasy_fade.sv
// Bench for fantasy_fade: random frames against a plain-arithmetic reference,
// with two instances (STEP=1 and STEP=5) sharing the same stimulus.
module tb_fantasy_fade;

  localparam int A = 16;
  localparam int M = 255;

  logic        vin_clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        vin_hs_i = 1'b0, vin_vs_i = 1'b0, vin_de_i = 1'b0;
  logic [23:0] vin_data_i = '0;
  logic        px_x_i = 1'b0;
  logic [2:0]  mode_i = '0;
  logic        bypass_i = 1'b0;

  logic        vout_hs_o, vout_vs_o, vout_de_o, fade_busy_o;
  logic [23:0] vout_data_o;
  logic [4:0]  alpha_o;
  logic        hs5, vs5, de5, busy5;
  logic [23:0] data5;
  logic [4:0]  alpha5;

  fantasy_fade #(.CW(8), .NC(3), .AW(4), .STEP(1), .VS_POL(1)) dut (
    .vin_clk_i(vin_clk_i), .rst_n(rst_n), .vin_hs_i(vin_hs_i), .vin_vs_i(vin_vs_i),
    .vin_de_i(vin_de_i), .vin_data_i(vin_data_i), .px_x_i(px_x_i), .mode_i(mode_i),
    .bypass_i(bypass_i), .vout_hs_o(vout_hs_o), .vout_vs_o(vout_vs_o),
    .vout_de_o(vout_de_o), .vout_data_o(vout_data_o), .alpha_o(alpha_o),
    .fade_busy_o(fade_busy_o));

  fantasy_fade #(.CW(8), .NC(3), .AW(4), .STEP(5), .VS_POL(1)) dut5 (
    .vin_clk_i(vin_clk_i), .rst_n(rst_n), .vin_hs_i(vin_hs_i), .vin_vs_i(vin_vs_i),
    .vin_de_i(vin_de_i), .vin_data_i(vin_data_i), .px_x_i(px_x_i), .mode_i(mode_i),
    .bypass_i(bypass_i), .vout_hs_o(hs5), .vout_vs_o(vs5),
    .vout_de_o(de5), .vout_data_o(data5), .alpha_o(alpha5),
    .fade_busy_o(busy5));

  always #5 vin_clk_i = ~vin_clk_i;

  typedef struct {
    logic        hs, vs, de;
    logic [23:0] d1, d5;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   al1 = 0, al5 = 0, tgt = 0, ptgt = 0, pend = 0;
  logic last_vs = 1'b0;
  int   exp5_up[4] = '{5, 10, 15, 16};
  int   exp5_dn[4] = '{11, 6, 1, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int step_to(int a, int t, int s);
    if (a < t) return (a + s > t) ? t : a + s;
    return (a - s < t) ? t : a - s;
  endfunction

  function automatic logic [23:0] ref_px(logic [23:0] d, int a);
    logic [23:0] r;
    int v, o;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      v = int'(d[k*8 +: 8]);
      o = (v * (A - a) + (M - v) * a + A / 2) / A;
      r[k*8 +: 8] = 8'(o);
    end
    return r;
  endfunction

  function automatic bit inv_of(logic [2:0] md, logic px, logic byp);
    if (byp || md == 3'd0) return 1'b0;
    if (md == 3'd1) return 1'b1;
    return (md % 2 == 0) ? px : !px;
  endfunction

  // One pixel clock: drive, predict, advance, then compare the 3-cycle-old pixel.
  task automatic cyc(input logic hs, input logic vs, input logic de,
                     input logic [23:0] d, input logic px);
    exp_t e;
    bit inv;
    vin_hs_i = hs; vin_vs_i = vs; vin_de_i = de; vin_data_i = d; px_x_i = px;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        al1 = step_to(al1, ptgt, 1);
        al5 = step_to(al5, ptgt, 5);
        tgt = ptgt;
      end
    end
    if (vs && !last_vs) begin
      pend = 2;
      ptgt = (mode_i == 3'd0) ? 0 : A;
    end
    last_vs = vs;
    inv = inv_of(mode_i, px, bypass_i);
    e.hs = hs; e.vs = vs; e.de = de;
    e.d1 = ref_px(d, inv ? al1 : 0);
    e.d5 = ref_px(d, inv ? al5 : 0);
    q.push_back(e);
    @(posedge vin_clk_i); #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("sync", 32'({vout_hs_o, vout_vs_o, vout_de_o}), 32'({e.hs, e.vs, e.de}));
      chk("sync5", 32'({hs5, vs5, de5}), 32'({e.hs, e.vs, e.de}));
      chk("data", 32'(vout_data_o), 32'(e.d1));
      chk("data5", 32'(data5), 32'(e.d5));
    end
    if (pend == 0) begin
      chk("alpha", 32'(alpha_o), 32'(al1));
      chk("alpha5", 32'(alpha5), 32'(al5));
      chk("busy", 32'(fade_busy_o), 32'(al1 != tgt));
      chk("busy5", 32'(busy5), 32'(al5 != tgt));
    end
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out", 32'({vout_hs_o, vout_vs_o, vout_de_o, fade_busy_o}), 32'(0));
    chk("rst_data", 32'(vout_data_o), 32'(0));
    chk("rst_alpha", 32'(alpha_o), 32'(0));
    chk("rst_out5", 32'({hs5, vs5, de5, busy5, data5}), 32'(0));
    chk("rst_alpha5", 32'(alpha5), 32'(0));
    vin_hs_i = 1'b0; vin_vs_i = 1'b0; vin_de_i = 1'b0;
    @(posedge vin_clk_i); @(posedge vin_clk_i); #1;
    rst_n = 1'b1;
    q.delete();
    al1 = 0; al5 = 0; tgt = 0; ptgt = 0; pend = 0; last_vs = 1'b0;
  endtask

  // Multi-cycle vsync, blanking, active pixels, trailing blanking.
  task automatic frame(input logic [2:0] fmode, input int npix, input bit mix, input bit byp_rand);
    mode_i = fmode; bypass_i = 1'b0;
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 24'($urandom), 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0);
    for (int i = 0; i < npix; i++) begin
      if (mix) mode_i = 3'($urandom_range(7));
      if (byp_rand) bypass_i = 1'($urandom_range(1));
      cyc(1'($urandom_range(1)), 1'b0, 1'b1, 24'($urandom), 1'($urandom_range(1)));
    end
    mode_i = fmode; bypass_i = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 24'($urandom), 1'b0);
  endtask

  task automatic pix_dir(input string tag, input logic [23:0] d, input logic px, input logic [23:0] e);
    cyc(1'b1, 1'b0, 1'b1, d, px);
    cyc(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    chk(tag, 32'(vout_data_o), 32'(e));
    chk({tag, "_de"}, 32'(vout_de_o), 32'(1));
  endtask

  initial begin
    do_reset();
    frame(3'd0, 8, 1'b0, 1'b0);
    chk("direct_alpha", 32'(alpha_o), 32'(0));

    for (int i = 0; i < 4; i++) begin
      frame(3'd1, 6, (i == 2), 1'b0);
      chk("ramp_alpha", 32'(alpha_o), 32'(i + 1));
      chk("ramp_alpha5", 32'(alpha5), 32'(exp5_up[i]));
    end
    for (int i = 4; i < 8; i++) frame(3'd1, 6, 1'b0, 1'b0);
    chk("alpha8", 32'(alpha_o), 32'(8));
    pix_dir("half_blend", 24'h404040, 1'b0, 24'h808080);

    for (int i = 8; i < 16; i++) begin
      frame(3'd1, 6, 1'b0, 1'b0);
      if (i == 14) chk("busy_at15", 32'({fade_busy_o, alpha_o}), 32'({1'b1, 5'd15}));
    end
    chk("done_at16", 32'({fade_busy_o, alpha_o}), 32'({1'b0, 5'd16}));
    pix_dir("full_inv", 24'h121212, 1'b0, 24'hEDEDED);

    mode_i = 3'd2;
    for (int i = 0; i < 8; i++) cyc(1'(i % 2), 1'b0, 1'b1, 24'($urandom), 1'(i % 2 == 0));
    pix_dir("dark_px1", 24'h102030, 1'b1, 24'hEFDFCF);
    pix_dir("dark_px0", 24'h102030, 1'b0, 24'h102030);

    mode_i = 3'd1; bypass_i = 1'b1;
    pix_dir("bypass", 24'h121212, 1'b0, 24'h121212);
    bypass_i = 1'b0;
    frame(3'd1, 10, 1'b0, 1'b1);
    chk("bypass_alpha", 32'(alpha_o), 32'(16));

    for (int i = 0; i < 4; i++) begin
      frame(3'd0, 4, 1'b0, 1'b0);
      chk("down_alpha", 32'(alpha_o), 32'(15 - i));
      chk("down_alpha5", 32'(alpha5), 32'(exp5_dn[i]));
    end

    do_reset();
    frame(3'd1, 6, 1'b1, 1'b1);
    chk("post_rst_alpha", 32'(alpha_o), 32'(1));
    chk("post_rst_alpha5", 32'(alpha5), 32'(5));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
